// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, burst limits and helpers for the AXI3 masters in this slice.
package axi3_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } wr_state_e;

  localparam int unsigned BOUNDARY_4K = 4096;
  localparam int unsigned MAX_BURST   = 16;

  // AxSIZE encoding: log2 of the number of bytes per beat.
  function automatic logic [2:0] size_of(input int unsigned data_w);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == data_w / 8) sz = i[2:0];
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi3_if.sv
// AXI3 channel bundle with master (m) and slave (s) views.
interface axi3_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi3_blen_calc.sv
// Burst length for the next INCR burst: min(16, remaining beats, beats left before 4 KB).
module axi3_blen_calc
  import axi3_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int BYTES = 8
) (
  input  logic [11:0]      addr_lo,
  input  logic [CNT_W-1:0] rem,
  output logic [4:0]       blen
);
  localparam int SHIFT = $clog2(BYTES);

  logic [12:0] bytes_to_4k;
  logic [12:0] beats_to_4k;

  // NOTE: blocking assignments in always_comb, every output given a value before any branch.
  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    beats_to_4k = bytes_to_4k >> SHIFT;
    blen        = 5'(MAX_BURST);
    if (beats_to_4k < 13'(MAX_BURST)) blen = beats_to_4k[4:0];
    if (rem < CNT_W'(blen))           blen = rem[4:0];
  end
endmodule

// File: rtl/axi3_wr_burst.sv
// AXI3 INCR write master: pushes len_words stream beats to memory in bursts of at most
// 16 beats that never cross a 4 KB boundary, with a single burst in flight (AW, W, B).
module axi3_wr_burst
  import axi3_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6,
  parameter int AXI_ID = 0,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  len_words,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  axi3_if.m                 axi
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [4:0]        blen_q, blen_d, blen_new;
  logic [3:0]        beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rready_q;
  logic              in_w, last_beat, w_hs;

  assign in_w      = (state_q == S_W);
  assign last_beat = (beat_q == 4'(blen_q - 5'd1));
  assign w_hs      = in_w && s_valid && axi.wready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    // busy drops the cycle after the done pulse unless a new start is taken right then.
    if (done_q) busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = {base_addr[ADDR_W-1:SHIFT], {SHIFT{1'b0}}};
          rem_d   = len_words;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = (len_words != '0) ? S_AW : S_DONE;
        end
      end
      S_AW: begin
        if (axi.awready) begin
          beat_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          beat_d = beat_q + 4'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        if (axi.bvalid) begin
          if (axi.bresp != RESP_OKAY) err_d = 1'b1;
          addr_d  = addr_q + (ADDR_W'(blen_q) << SHIFT);
          rem_d   = rem_q - CNT_W'(blen_q);
          state_d = (rem_d != '0) ? S_AW : S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fed from the next-state address/count so blen is ready in the first AW cycle.
  axi3_blen_calc #(
    .CNT_W(CNT_W),
    .BYTES(BYTES)
  ) u_blen_calc (
    .addr_lo(addr_d[11:0]),
    .rem    (rem_d),
    .blen   (blen_new)
  );

  always_comb begin
    blen_d = blen_q;
    if (state_d == S_AW && state_q != S_AW) blen_d = blen_new;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rready_q <= 1'b1;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  assign axi.awid    = ID_W'(AXI_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'(blen_q - 5'd1);
  assign axi.awsize  = size_of(DATA_W);
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0011;
  assign axi.awprot  = 3'b000;
  assign axi.awqos   = 4'b0000;
  assign axi.awvalid = (state_q == S_AW);

  // Stream is passed straight through; stalls on either side show up as wvalid/s_ready low.
  assign axi.wid    = ID_W'(AXI_ID);
  assign axi.wdata  = s_data;
  assign axi.wstrb  = '1;
  assign axi.wvalid = in_w && s_valid;
  assign axi.wlast  = in_w && last_beat;
  assign s_ready    = in_w && axi.wready;

  assign axi.bready = (state_q == S_B);

  assign axi.arid    = '0;
  assign axi.araddr  = '0;
  assign axi.arlen   = '0;
  assign axi.arsize  = '0;
  assign axi.arburst = '0;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arqos   = '0;
  assign axi.arvalid = 1'b0;
  assign axi.rready  = rready_q;

  logic unused_inputs;
  assign unused_inputs = ^{axi.bid, axi.arready, axi.rid, axi.rdata, axi.rresp,
                           axi.rlast, axi.rvalid, base_addr[SHIFT-1:0]};
endmodule

// File: tb/tb_axi3_wr_burst.sv
// Self-checking bench for axi3_wr_burst: command table plus hand-written reset sequence.
module tb_axi3_wr_burst;
  import axi3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] len_words = '0;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_ready, busy, done, err;

  always #5 clk = ~clk;

  axi3_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) axi ();

  axi3_wr_burst #(
    .ADDR_W(32), .DATA_W(64), .ID_W(6), .AXI_ID(0), .CNT_W(24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len_words(len_words),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .axi      (axi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [23:0] len;
    logic [1:0]  resp;
    bit          bp;
    int          restart_at;
    int          nb;
    logic [95:0] ea;      // {addr2, addr1, addr0}
    logic [11:0] el;      // {awlen2, awlen1, awlen0}
    bit          exp_err;
  } vec_t;

  logic [31:0] aw_addr_log[$];
  logic [3:0]  aw_len_log[$];
  logic [63:0] data_log[$];
  int          wlast_log[$];
  int          done_cnt, done_k, first_aw_k, sready_viol, awb_viol, extra_aw;
  bit          err_at_done, busy_at_done, busy_after, timed_out;

  task automatic run_cmd(input logic [31:0] base, input logic [23:0] len, input logic [1:0] resp,
                         input bit bp, input int restart_at, input int reset_at);
    int          b_pending = 0;
    int          beats = 0;
    int          last_b_k = -1;
    logic [63:0] next_word = 64'd1;
    bit          prev_aw = 1'b0;
    bit          finished = 1'b0;
    bit          was_reset = 1'b0;
    aw_addr_log.delete(); aw_len_log.delete(); data_log.delete(); wlast_log.delete();
    done_cnt = 0; done_k = -1; first_aw_k = -1; sready_viol = 0; awb_viol = 0; extra_aw = 0;
    err_at_done = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1; timed_out = 1'b0;
    axi.awready = 1'b1; axi.bvalid = 1'b0; axi.bresp = resp; axi.wready = 1'b0;
    @(negedge clk);
    base_addr = base; len_words = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) begin
        base_addr = 32'hDEAD_0000;
        len_words = 24'd7;
      end
      axi.wready = bp ? (k % 2 == 0) : 1'b1;
      s_valid    = bp ? (k % 4 == 1 || k % 4 == 2) : 1'b1;
      s_data     = next_word;
      axi.bvalid = (b_pending > 0);
      #1;
      if (axi.awvalid && !prev_aw) begin
        if (first_aw_k < 0) first_aw_k = k;
        if (last_b_k >= 0 && k != last_b_k + 1) awb_viol++;
      end
      prev_aw = axi.awvalid;
      if (axi.awvalid && axi.awready) begin
        aw_addr_log.push_back(axi.awaddr);
        aw_len_log.push_back(axi.awlen);
      end
      if (s_ready && !axi.wready) sready_viol++;
      if (axi.wvalid && axi.wready) begin
        data_log.push_back(axi.wdata);
        beats++;
        next_word++;
        if (axi.wlast) begin
          wlast_log.push_back(beats);
          b_pending++;
        end
      end
      if (axi.bvalid && axi.bready) begin
        b_pending--;
        last_b_k = k;
      end
      if (done) begin
        done_cnt++;
        done_k       = k;
        err_at_done  = err;
        busy_at_done = busy;
      end else if (done_k >= 0 && k == done_k + 1) begin
        busy_after = busy;
        finished   = 1'b1;
      end
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs_immediate",
              {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, s_ready, busy, done, err,
               axi.arvalid, axi.rready}, 10'b0);
        finished  = 1'b1;
        was_reset = 1'b1;
      end
    end
    if (!finished) timed_out = 1'b1;
    start = 1'b0;
    axi.bvalid = 1'b0;
    s_valid = 1'b0;
    if (!was_reset) begin
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        #1;
        if (done) done_cnt++;
        if (axi.awvalid) extra_aw++;
      end
    end
  endtask

  task automatic check_vec(input vec_t v);
    int bad;
    int pos;
    int exp_first;
    check({v.name, "_timeout"}, 64'(timed_out), 64'd0);
    check({v.name, "_n_bursts"}, 64'(aw_addr_log.size()), 64'(v.nb));
    for (int i = 0; i < v.nb && i < aw_addr_log.size(); i++) begin
      check($sformatf("%s_awaddr%0d", v.name, i), 64'(aw_addr_log[i]), 64'(v.ea[32*i +: 32]));
      check($sformatf("%s_awlen%0d", v.name, i), 64'(aw_len_log[i]), 64'(v.el[4*i +: 4]));
    end
    check({v.name, "_beats"}, 64'(data_log.size()), 64'(v.len));
    bad = 0;
    foreach (data_log[i]) if (data_log[i] != 64'(i + 1)) bad++;
    check({v.name, "_data_order"}, 64'(bad), 64'd0);
    check({v.name, "_n_wlast"}, 64'(wlast_log.size()), 64'(v.nb));
    bad = 0;
    pos = 0;
    for (int i = 0; i < v.nb && i < wlast_log.size(); i++) begin
      pos += int'(v.el[4*i +: 4]) + 1;
      if (wlast_log[i] != pos) bad++;
    end
    check({v.name, "_wlast_pos"}, 64'(bad), 64'd0);
    check({v.name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({v.name, "_err_at_done"}, 64'(err_at_done), 64'(v.exp_err));
    check({v.name, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
    check({v.name, "_busy_after_done"}, 64'(busy_after), 64'd0);
    exp_first = (v.nb > 0) ? 0 : -1;
    check({v.name, "_aw_latency"}, 64'(first_aw_k), 64'(exp_first));
    check({v.name, "_aw_after_b"}, 64'(awb_viol), 64'd0);
    check({v.name, "_sready_wo_wready"}, 64'(sready_viol), 64'd0);
    check({v.name, "_no_aw_after_done"}, 64'(extra_aw), 64'd0);
    if (v.nb == 0) check({v.name, "_done_cycle"}, 64'(done_k), 64'd1);
    if (v.exp_err) check({v.name, "_err_sticky_idle"}, 64'(err), 64'd1);
  endtask

  vec_t tv[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{"len40", 32'h1000_0000, 24'd40, RESP_OKAY, 1'b0, -1, 3,
               {32'h1000_0100, 32'h1000_0080, 32'h1000_0000}, {4'd7, 4'd15, 4'd15}, 1'b0};
    tv[1]  = '{"cross4k", 32'h1000_0FC0, 24'd20, RESP_OKAY, 1'b0, -1, 2,
               {32'h0, 32'h1000_1000, 32'h1000_0FC0}, {4'd0, 4'd11, 4'd7}, 1'b0};
    tv[2]  = '{"slverr", 32'h2000_0000, 24'd16, RESP_SLVERR, 1'b0, -1, 1,
               {32'h0, 32'h0, 32'h2000_0000}, {4'd0, 4'd0, 4'd15}, 1'b1};
    tv[3]  = '{"okay_clears", 32'h2000_1000, 24'd3, RESP_OKAY, 1'b0, -1, 1,
               {32'h0, 32'h0, 32'h2000_1000}, {4'd0, 4'd0, 4'd2}, 1'b0};
    tv[4]  = '{"edge_ff8", 32'h3000_0FF8, 24'd3, RESP_OKAY, 1'b0, -1, 2,
               {32'h0, 32'h3000_1000, 32'h3000_0FF8}, {4'd0, 4'd1, 4'd0}, 1'b0};
    tv[5]  = '{"unaligned", 32'h4000_0007, 24'd2, RESP_OKAY, 1'b0, -1, 1,
               {32'h0, 32'h0, 32'h4000_0000}, {4'd0, 4'd0, 4'd1}, 1'b0};
    tv[6]  = '{"addr_wrap", 32'hFFFF_FF80, 24'd20, RESP_OKAY, 1'b0, -1, 2,
               {32'h0, 32'h0000_0000, 32'hFFFF_FF80}, {4'd0, 4'd3, 4'd15}, 1'b0};
    tv[7]  = '{"backpressure", 32'h5000_0000, 24'd5, RESP_OKAY, 1'b1, -1, 1,
               {32'h0, 32'h0, 32'h5000_0000}, {4'd0, 4'd0, 4'd4}, 1'b0};
    tv[8]  = '{"len0", 32'h6000_0000, 24'd0, RESP_OKAY, 1'b0, -1, 0,
               {32'h0, 32'h0, 32'h0}, {4'd0, 4'd0, 4'd0}, 1'b0};
    tv[9]  = '{"decerr_multi", 32'h7000_0000, 24'd24, RESP_DECERR, 1'b0, -1, 2,
               {32'h0, 32'h7000_0080, 32'h7000_0000}, {4'd0, 4'd7, 4'd15}, 1'b1};
    tv[10] = '{"restart_in_w", 32'h9000_0000, 24'd20, RESP_OKAY, 1'b0, 4, 2,
               {32'h0, 32'h9000_0080, 32'h9000_0000}, {4'd0, 4'd3, 4'd15}, 1'b0};

    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.bid = '0; axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;

    #3;
    check("reset_state",
          {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, s_ready, busy, done, err,
           axi.arvalid, axi.rready}, 10'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("const_awsize", 64'(axi.awsize), 64'd3);
    check("const_awburst", 64'(axi.awburst), 64'(BURST_INCR));
    check("const_awcache", 64'(axi.awcache), 64'h3);
    check("const_ids", 64'({axi.awid, axi.wid}), 64'd0);
    check("const_wstrb", 64'(axi.wstrb), 64'hFF);
    check("const_lock_prot_qos", 64'({axi.awlock, axi.awprot, axi.awqos}), 64'd0);
    check("read_tieoff", 64'({axi.arvalid, axi.araddr, axi.rready}), 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_cmd(tv[i].base, tv[i].len, tv[i].resp, tv[i].bp, tv[i].restart_at, -1);
      check_vec(tv[i]);
    end

    // Reset in the middle of the second burst's data phase, then a normal command.
    run_cmd(32'hA000_0000, 24'd40, RESP_OKAY, 1'b0, -1, 20);
    check("reset_mid_burst_was_in_w", 64'(data_log.size()), 64'd18);
    @(negedge clk);
    #1;
    check("reset_held_idle", 64'({axi.awvalid, axi.wvalid, busy, done, err}), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_reset_idle", 64'({axi.awvalid, axi.wvalid, axi.bready, busy}), 64'd0);
    end
    run_cmd(tv[0].base, tv[0].len, tv[0].resp, tv[0].bp, -1, -1);
    check_vec(tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi3_wr_burst.md
Name: axi3_wr_burst

Overview:
- AXI3 write master that turns a valid/ready data stream into INCR write bursts on an axi3_if master modport, e.g. a Zynq S_AXI_HP port into DDR.
- Sits directly upstream of the AXI3 interface. It consumes a start command (byte address, beat count) and pushes all stream words to memory.
- Bursts are at most 16 beats and never cross a 4 KB boundary.
- One burst is outstanding at a time: AW, then W, then B.

Parameters:
- ADDR_W, 32, address width; must match the bound axi3_if.
- DATA_W, 64, data width in bits (32/64/128); must match the bound axi3_if.
- ID_W, 6, ID width; must match the bound axi3_if.
- AXI_ID, 0, constant driven on awid and wid.
- CNT_W, 24, width of the beat-count command.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored (forced 0).
- len_words  in  CNT_W  number of DATA_W beats to write.
- s_valid  in  1  stream data valid.
- s_data  in  DATA_W  stream data.
- s_ready  out  1  stream data accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky for the command: any bresp != OKAY; cleared on the next accepted start.
- axi  modport  axi3_if.m  AXI3 master side.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, s_ready, awvalid, wvalid, wlast, bready = 0; address and counters = 0; arvalid = 0, rready = 0.
- Constant outputs:
  - awburst=2'b01 (INCR), awsize=log2(DATA_W/8), awcache=4'b0011, awlock=0, awprot=0, awqos=0.
  - awid = wid = AXI_ID; wstrb = all ones.
  - Read channel tied off (arvalid=0, rready=1, ar* payload 0).
- FSM states: IDLE, AW, W, B, DONE.
  - IDLE: on start, latch addr and rem=len_words, set busy=1, clear err. Next state is AW if len_words!=0, else DONE. A start outside IDLE is ignored.
  - AW: awvalid=1, awaddr=addr, awlen=blen-1.
    - blen = min(16, rem, beats_to_4k), where beats_to_4k = (4096 - addr[11:0]) / (DATA_W/8).
    - blen is registered on AW entry and held stable while awvalid=1.
    - On awready: go to W, beat=0.
  - W: wvalid = s_valid; s_ready = wready; wdata = s_data; wlast = (beat == blen-1).
    - Pass-through is combinational; no stream buffering.
    - Each handshake (s_valid & wready) increments beat.
    - On the wlast handshake: go to B.
  - B: bready=1. On bvalid:
    - if bresp != 2'b00, set err=1;
    - addr += blen*(DATA_W/8); rem -= blen;
    - next state is AW if rem != 0, else DONE.
  - DONE: done=1 for exactly one cycle, busy=0 on the following cycle; return to IDLE.
- Latency: awvalid rises the cycle after start is accepted. The next burst's awvalid rises the cycle after the B handshake.
- An error response does not abort the command; all remaining bursts are still issued.
- s_ready=0 outside W, including during AW and B; stream stalls are absorbed by wvalid=0.
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-burst abandons the transaction. System rule: the slave is reset in the same domain.

Decomposition:
- Shared package axi3_pkg holds:
  - burst encodings (FIXED/INCR/WRAP);
  - resp encodings (OKAY, EXOKAY, SLVERR, DECERR);
  - the 4 KB boundary constant, MAX_BURST=16;
  - the function size_of(DATA_W) returning awsize.
- One sub-module: axi3_blen_calc, the combinational min(16, rem, beats_to_4k) calculator. It is reusable by a future read master.

Test Plan:
1. DATA_W=64, base 0x1000_0000, len 40, s_valid=1, wready=1 -> three AW at 0x1000_0000, 0x1000_0080, 0x1000_0100 with awlen 15, 15, 7; wlast on beats 16/32/40; one done pulse; err=0.
2. Base 0x1000_0FC0, len 20 -> AW at 0x1000_0FC0 with awlen 7, then AW at 0x1000_1000 with awlen 11; no burst crosses 0x1000.
3. len 16, bresp=SLVERR on the only B -> err=1 with the done pulse. A following start with OKAY responses clears err=0.
4. Backpressure: wready toggling 1010..., s_valid toggling 0110..., len 5 -> exactly 5 beats transferred in order (data 1..5), s_ready never high with wready low, wlast only on beat 5.
5. len_words=0 -> no awvalid; done pulses 2 cycles after start.
6. start re-asserted during W, and rst_n pulsed low mid-burst -> second start ignored; on reset all outputs 0 immediately, state IDLE, a new start operates normally.
